// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control sequencer and the datapath
// muxes it steers: state encoding, opcodes and select codes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_FETCH_WR,
      S_DECODE,
      S_R_EXEC,
      S_R_WB,
      S_I_EXEC,
      S_I_WB,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [3:0] SRCB_REG     = 4'b0000;
   localparam logic [3:0] SRCB_FOUR    = 4'b0001;
   localparam logic [3:0] SRCB_IMM     = 4'b0010;
   localparam logic [3:0] SRCB_IMM_SL2 = 4'b0011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef struct packed {
      logic       alu_src_a;
      logic [3:0] alu_src_b;
      logic [1:0] alu_op;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_rd;
      logic       mem_wr;
      logic       ir_write;
      logic       ab_write;
      logic       alu_out_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/mem_wait_cnt.sv
// Memory latency counter: counts cycles spent in a wait state and flags the
// last one so the sequencer can leave after exactly MEM_LAT cycles.
module mem_wait_cnt #(
   parameter int MEM_LAT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam int CW = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= cnt + 1'b1;
   end

   assign done = enable && (cnt == LAST);

endmodule

// File: rtl/mc_control_seq.sv
// Multicycle control sequencer: Moore FSM producing every datapath select
// and enable line from the current state and the memory wait counter.
module mc_control_seq
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   output logic       alu_src_a,
   output logic [3:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       ir_write,
   output logic       ab_write,
   output logic       alu_out_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal
);

   state_t state, state_nxt;
   ctrl_t  ctrl, ctrl_out;
   logic   wait_st, wait_done;

   assign wait_st = (state == S_FETCH) || (state == S_MEM_RD);

   // Held clear in every other state, so it is already 0 on entry.
   mem_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait (
      .clk    (clk),
      .reset  (reset),
      .clear  (!wait_st),
      .enable (wait_st),
      .done   (wait_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH;
      else        state <= state_nxt;
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      ctrl      = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_rd = 1'b1;
            if (wait_done) state_nxt = S_FETCH_WR;
         end
         S_FETCH_WR: begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_src    = PC_ALU;
            state_nxt      = S_DECODE;
         end
         S_DECODE: begin
            ctrl.ab_write      = 1'b1;
            ctrl.alu_out_write = 1'b1;
            ctrl.alu_src_b     = SRCB_IMM_SL2;
            ctrl.alu_op        = ALU_ADD;
            case (opcode)
               OP_RTYPE:      state_nxt = S_R_EXEC;
               OP_ADDI:       state_nxt = S_I_EXEC;
               OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
               OP_BEQ:        state_nxt = S_BRANCH;
               OP_J:          state_nxt = S_JUMP;
               default: begin
                  ctrl.illegal = 1'b1;
                  state_nxt    = S_FETCH;
               end
            endcase
         end
         S_R_EXEC: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALU_FUNCT;
            ctrl.alu_out_write = 1'b1;
            state_nxt          = S_R_WB;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            state_nxt      = S_FETCH;
         end
         S_I_EXEC, S_MEM_ADDR: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_IMM;
            ctrl.alu_op        = ALU_ADD;
            ctrl.alu_out_write = 1'b1;
            if (state == S_I_EXEC)    state_nxt = S_I_WB;
            else if (opcode == OP_LW) state_nxt = S_MEM_RD;
            else                      state_nxt = S_MEM_WR;
         end
         S_I_WB: begin
            ctrl.reg_write = 1'b1;
            state_nxt      = S_FETCH;
         end
         S_MEM_RD: begin
            ctrl.mem_rd = 1'b1;
            ctrl.iord   = 1'b1;
            if (wait_done) state_nxt = S_MEM_WB;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            state_nxt       = S_FETCH;
         end
         S_MEM_WR: begin
            ctrl.mem_wr = 1'b1;
            ctrl.iord   = 1'b1;
            state_nxt   = S_FETCH;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = PC_ALUOUT;
            ctrl.pc_write  = zero;
            state_nxt      = S_FETCH;
         end
         S_JUMP: begin
            ctrl.pc_src   = PC_JUMP;
            ctrl.pc_write = 1'b1;
            state_nxt     = S_FETCH;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   // Outputs are forced low combinationally while reset is held, so an
   // in-flight write-back is cut off in the same cycle reset arrives.
   assign ctrl_out = reset ? ctrl : '0;

   assign alu_src_a     = ctrl_out.alu_src_a;
   assign alu_src_b     = ctrl_out.alu_src_b;
   assign alu_op        = ctrl_out.alu_op;
   assign pc_write      = ctrl_out.pc_write;
   assign pc_src        = ctrl_out.pc_src;
   assign iord          = ctrl_out.iord;
   assign mem_rd        = ctrl_out.mem_rd;
   assign mem_wr        = ctrl_out.mem_wr;
   assign ir_write      = ctrl_out.ir_write;
   assign ab_write      = ctrl_out.ab_write;
   assign alu_out_write = ctrl_out.alu_out_write;
   assign reg_write     = ctrl_out.reg_write;
   assign reg_dst       = ctrl_out.reg_dst;
   assign mem_to_reg    = ctrl_out.mem_to_reg;
   assign illegal       = ctrl_out.illegal;

endmodule

// File: tb/tb_mc_control_seq.sv
// Self-checking bench for mc_control_seq: per-instruction expected output
// traces are built from the instruction-level behaviour and compared cycle by cycle.
module tb_mc_control_seq;

   localparam int L = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       alu_src_a;
   logic [3:0] alu_src_b;
   logic [1:0] alu_op;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       iord, mem_rd, mem_wr, ir_write, ab_write, alu_out_write;
   logic       reg_write, reg_dst, mem_to_reg, illegal;

   typedef struct packed {
      logic       src_a;
      logic [3:0] src_b;
      logic [1:0] aop;
      logic       pcw;
      logic [1:0] pcs;
      logic       iord;
      logic       mrd;
      logic       mwr;
      logic       irw;
      logic       abw;
      logic       aow;
      logic       rw;
      logic       rdst;
      logic       m2r;
      logic       ill;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   vec_t exp_q[$];

   mc_control_seq #(.MEM_LAT(L)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .zero          (zero),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_write      (pc_write),
      .pc_src        (pc_src),
      .iord          (iord),
      .mem_rd        (mem_rd),
      .mem_wr        (mem_wr),
      .ir_write      (ir_write),
      .ab_write      (ab_write),
      .alu_out_write (alu_out_write),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .illegal       (illegal)
   );

   always #5 clk = ~clk;

   function automatic vec_t observed();
      return {alu_src_a, alu_src_b, alu_op, pc_write, pc_src, iord, mem_rd,
              mem_wr, ir_write, ab_write, alu_out_write, reg_write, reg_dst,
              mem_to_reg, illegal};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_branch(input logic [5:0] op);
      return op == 6'h04;
   endfunction

   // Expected per-cycle trace of one whole instruction.
   function automatic void build(input logic [5:0] op, input bit z);
      vec_t o;
      exp_q.delete();
      repeat (L) begin o = '0; o.mrd = 1; exp_q.push_back(o); end
      o = '0; o.irw = 1; o.pcw = 1; o.src_b = 4'b0001; exp_q.push_back(o);
      o = '0; o.abw = 1; o.aow = 1; o.src_b = 4'b0011;
      o.ill = !(op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02});
      exp_q.push_back(o);
      case (op)
         6'h00: begin
            o = '0; o.src_a = 1; o.aop = 2'b10; o.aow = 1; exp_q.push_back(o);
            o = '0; o.rw = 1; o.rdst = 1; exp_q.push_back(o);
         end
         6'h08, 6'h23, 6'h2B: begin
            o = '0; o.src_a = 1; o.src_b = 4'b0010; o.aow = 1; exp_q.push_back(o);
            if (op == 6'h08) begin
               o = '0; o.rw = 1; exp_q.push_back(o);
            end else if (op == 6'h23) begin
               repeat (L) begin o = '0; o.mrd = 1; o.iord = 1; exp_q.push_back(o); end
               o = '0; o.rw = 1; o.m2r = 1; exp_q.push_back(o);
            end else begin
               o = '0; o.mwr = 1; o.iord = 1; exp_q.push_back(o);
            end
         end
         6'h04: begin
            o = '0; o.src_a = 1; o.aop = 2'b01; o.pcs = 2'b01; o.pcw = z; exp_q.push_back(o);
         end
         6'h02: begin
            o = '0; o.pcs = 2'b10; o.pcw = 1; exp_q.push_back(o);
         end
         default: ;
      endcase
   endfunction

   function automatic int exp_len(input logic [5:0] op);
      case (op)
         6'h00, 6'h08, 6'h2B: return L + 4;
         6'h23:               return 2 * L + 4;
         6'h04, 6'h02:        return L + 3;
         default:             return L + 2;
      endcase
   endfunction

   // Entered 1 time unit after a rising edge at the start of a FETCH.
   // abort_at >= 0 asserts reset right after checking that cycle.
   task automatic run_instr(input logic [5:0] op, input bit z, input int abort_at, input string name);
      int n;
      build(op, z);
      n = exp_q.size();
      check($sformatf("%s_len", name), 32'(n), 32'(exp_len(op)));
      for (int i = 0; i < n; i++) begin
         opcode = (i < L + 1) ? 6'($urandom) : op;
         zero   = (is_branch(op) && i == L + 2) ? z : 1'($urandom);
         @(negedge clk);
         check($sformatf("%s_c%0d", name, i), 32'(observed()), 32'(exp_q[i]));
         if (i == abort_at) begin
            #2 reset = 1'b0;
            #1 check($sformatf("%s_abort", name), 32'(observed()), 32'd0);
            repeat (2) begin
               @(negedge clk);
               check($sformatf("%s_held", name), 32'(observed()), 32'd0);
            end
            @(posedge clk);
            #1 reset = 1'b1;
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [5:0] pool [7];
      logic [5:0] op;
      pool = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
      reset  = 1'b0;
      opcode = 6'h00;
      zero   = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs", 32'(observed()), 32'd0);
      end
      @(posedge clk);
      #1 reset = 1'b1;

      run_instr(6'h00, 1'b0, -1, "rtype");
      run_instr(6'h23, 1'b0, -1, "lw");
      run_instr(6'h04, 1'b1, -1, "beq_taken");
      run_instr(6'h04, 1'b0, -1, "beq_not");
      run_instr(6'h3F, 1'b0, -1, "illegal");
      run_instr(6'h2B, 1'b0, -1, "sw");
      run_instr(6'h08, 1'b0, -1, "addi");
      run_instr(6'h02, 1'b0, -1, "jump");
      run_instr(6'h23, 1'b0, 2 * L + 3, "lw_abort");
      run_instr(6'h00, 1'b0, -1, "after_abort");

      for (int k = 0; k < 300; k++) begin
         op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pool[$urandom_range(0, 6)];
         run_instr(op, 1'($urandom), -1, $sformatf("rnd%0d_op%02h", k, op));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_control_seq.md
# mc_control_seq

Multicycle control sequencer that drives the datapath's select and write-enable lines, including the 4-bit ALU-B source selector consumed by the ALU-B mux. It decodes the latched opcode and `zero` into a Moore FSM covering fetch, decode and per-instruction execute/memory/write-back states. It sits beside the datapath and is the only source of `alu_src_b`, `alu_op`, PC/IR/register-file enables and memory strobes. It also waits a fixed, parameterised number of cycles for memory.

## Interface
- `MEM_LAT`, 2: cycles `mem_rd` is held per memory read (≥1).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `zero`  in  1  ALU zero flag; sampled in BRANCH.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  4  0000 = B, 0001 = constant 4, 0010 = sign-extended immediate, 0011 = immediate<<2.
- `alu_op`  out  2  00 = ADD, 01 = SUB, 10 = use funct.
- `pc_write`  out  1  PC load enable.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_rd`, `mem_wr`  out  1 each  memory strobes.
- `ir_write`, `ab_write`, `alu_out_write`  out  1 each  register enables.
- `reg_write`, `reg_dst`, `mem_to_reg`  out  1 each  register-file controls.
- `illegal`  out  1  one-cycle pulse for an unsupported opcode.

## Operation
- Moore outputs decoded from `state` and the wait counter. Any output not listed for a state is 0.
- States and transitions:
  - FETCH: `mem_rd`, `iord`=0. Stays for MEM_LAT cycles, then goes to FETCH_WR.
  - FETCH_WR: `ir_write`, `pc_write`, `alu_src_a`=0, `alu_src_b`=0001, ADD, `pc_src`=00. Goes to DECODE.
  - DECODE: `ab_write`, `alu_out_write`, `alu_src_a`=0, `alu_src_b`=0011, ADD. Branches on opcode:
    - 0x00 goes to R_EXEC.
    - 0x08 goes to I_EXEC.
    - 0x23 and 0x2B go to MEM_ADDR.
    - 0x04 goes to BRANCH.
    - 0x02 goes to JUMP.
    - Any other opcode asserts `illegal` and returns to FETCH.
  - R_EXEC: `alu_src_a`=1, `alu_src_b`=0000, op 10, `alu_out_write`. Goes to R_WB.
  - R_WB: `reg_write`, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
  - I_EXEC: `alu_src_a`=1, `alu_src_b`=0010, ADD, `alu_out_write`. Goes to I_WB.
  - I_WB: `reg_write`, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
  - MEM_ADDR: same outputs as I_EXEC. Goes to MEM_RD for 0x23, or MEM_WR for 0x2B.
  - MEM_RD: `mem_rd`, `iord`=1. Stays for MEM_LAT cycles, then goes to MEM_WB.
  - MEM_WB: `reg_write`, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
  - MEM_WR: `mem_wr`, `iord`=1, one cycle. Goes to FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=0000, SUB, `pc_src`=01, `pc_write`=`zero`. Goes to FETCH.
  - JUMP: `pc_src`=10, `pc_write`. Goes to FETCH.
- Wait counter:
  - Width is $clog2(MEM_LAT+1).
  - Cleared on entry to FETCH or MEM_RD and increments each cycle in those states.
  - Exit occurs in the cycle where the counter equals MEM_LAT-1.
  - With MEM_LAT=1, FETCH and MEM_RD each last exactly one cycle.
- `opcode` is ignored outside DECODE and MEM_ADDR.

## Timing
- Reset asserted (asynchronous):
  - Next state is FETCH and the counter is 0.
  - All outputs are 0 while `reset` is low, including `mem_rd` and `alu_src_b`=0000.
- The first cycle after reset release is FETCH with `mem_rd`=1.
- Reset mid-instruction aborts immediately with no partial write-back; `reg_write` and `pc_write` drop in the same cycle.
- Instruction length in cycles, with L = MEM_LAT:
  - R-type, addi, sw: L+4.
  - lw: 2L+4.
  - beq, j: L+3.
  - Illegal opcode: L+2.
- `illegal` is high for exactly the one DECODE cycle and is never sticky.
- `zero` is used combinationally in BRANCH only. A `zero` glitch in other states has no effect.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J);
  - ALU-B selector codes (SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SL2);
  - ALU op codes and PC source codes.
- The ALU-B mux and this block both use the package selector codes.
- One sub-module: `mem_wait_cnt`, the parameterised latency counter. It has clear and enable inputs and a `done` output.

## Test plan
- Reset low for 3 cycles, then release, with L=2 → all outputs 0 during reset. After release, `mem_rd`=1 for 2 cycles, then FETCH_WR shows `alu_src_b`=0001, `pc_write`=1, `ir_write`=1.
- opcode=0x00 → sequence FETCH×2, FETCH_WR, DECODE (`alu_src_b`=0011), R_EXEC (`alu_src_b`=0000, `alu_op`=10), R_WB (`reg_write`=1, `reg_dst`=1). Total 6 cycles.
- opcode=0x23 → MEM_ADDR with `alu_src_b`=0010, then `mem_rd`=1 and `iord`=1 for 2 cycles, then MEM_WB with `mem_to_reg`=1. Total 8 cycles.
- opcode=0x04, run once with `zero`=1 and once with `zero`=0 → BRANCH `pc_write` is 1 and 0 respectively. `pc_src`=01 and `alu_op`=01 in both runs. Total 5 cycles.
- opcode=0x3F → `illegal` pulses exactly 1 cycle in DECODE, with no `reg_write`, `mem_wr` or `pc_write` beyond FETCH_WR. Next cycle is FETCH.
- Reset asserted during MEM_WB of an lw → `reg_write` falls asynchronously. After release, FETCH restarts with the counter at 0.
